// File: rtl/xor4_gate_tester.sv
// xor4_gate_tester: stimulus/checker for a quad 2-input XOR gate.
//
// On START it walks all 256 {A,B} combinations. Each vector is held for SETTLE wait cycles
// plus one check cycle. On the closing edge of the check cycle Y is compared with A^B, and
// any mismatch is counted. The block then reports DONE/PASS, the saturating mismatch count
// and the first failing vector.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous reset, active-high, priority over everything
//   START       run request, honoured only in IDLE or DONE
//   Y[3:0]      gate outputs under test
//   A[3:0]      registered stimulus operand A (idx[7:4])
//   B[3:0]      registered stimulus operand B (idx[3:0])
//   BUSY        high while a run is in progress
//   DONE        high from run completion until the next START
//   PASS        valid with DONE; 1 iff no mismatches
//   ERR_CNT     saturating mismatch count
//   FIRST_FAIL  {A,B} of the first mismatching vector, 0 if none
module xor4_gate_tester #(
  parameter int unsigned SETTLE = 2,  // legal range 1..15
  parameter int unsigned ERRW   = 9
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [3:0]      Y,
  output logic [3:0]      A,
  output logic [3:0]      B,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERR_CNT,
  output logic [7:0]      FIRST_FAIL
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCheck,
    StDone
  } state_e;

  localparam logic [3:0]      WaitLast = 4'(SETTLE - 1);
  localparam logic [ERRW-1:0] ErrMax   = '1;

  state_e          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [3:0]      wait_q, wait_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [7:0]      ff_q, ff_d;
  logic            pass_q, pass_d;
  logic            mismatch;

  // Compare against the registered operands only.
  assign mismatch = (Y != (idx_q[7:4] ^ idx_q[3:0]));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d = StWait;
          idx_d   = 8'h00;
          wait_d  = 4'h0;
          err_d   = '0;
          ff_d    = 8'h00;
          pass_d  = 1'b0;
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StCheck;
        end else begin
          wait_d = wait_q + 4'h1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != ErrMax) begin
            err_d = err_q + 1'b1;
          end
          // Count is saturating and never returns to zero, so zero means "no error yet".
          if (err_q == '0) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == 8'hFF) begin
          state_d = StDone;
          // Use the next count so the last vector's result is included.
          pass_d  = (err_d == '0);
        end else begin
          state_d = StWait;
          idx_d   = idx_q + 8'h01;
          wait_d  = 4'h0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      idx_q   <= 8'h00;
      wait_q  <= 4'h0;
      err_q   <= '0;
      ff_q    <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  assign A          = idx_q[7:4];
  assign B          = idx_q[3:0];
  assign BUSY       = (state_q == StWait) || (state_q == StCheck);
  assign DONE       = (state_q == StDone);
  assign PASS       = pass_q;
  assign ERR_CNT    = err_q;
  assign FIRST_FAIL = ff_q;

endmodule

// File: tb/tb_xor4_gate_tester.sv
// Bench for xor4_gate_tester: four instances with different SETTLE/ERRW share clock, reset
// and START; each has its own gate model (ideal, stuck bit, inverted, delayed, random faults).
module tb_xor4_gate_tester;

  localparam int S  [4] = '{2, 2, 1, 3};
  localparam int EW [4] = '{9, 4, 9, 9};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a [4];
  logic [3:0] b [4];
  logic [3:0] y [4];
  logic       busy [4];
  logic       done [4];
  logic       pass [4];
  logic [7:0] ff [4];
  logic [8:0] ec0, ec2, ec3;
  logic [3:0] ec1;

  // Gate model per instance: 0 ideal, 1 Y[0] stuck 0, 2 inverted, 3 delayed, 4 random faults
  int         mode [4];
  logic [3:0] mask [256];
  logic [3:0] pipe [4][3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xor4_gate_tester #(.SETTLE(2), .ERRW(9)) u0 (
    .CLK(clk), .RST(rst), .START(start), .Y(y[0]), .A(a[0]), .B(b[0]), .BUSY(busy[0]),
    .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(ec0), .FIRST_FAIL(ff[0])
  );
  xor4_gate_tester #(.SETTLE(2), .ERRW(4)) u1 (
    .CLK(clk), .RST(rst), .START(start), .Y(y[1]), .A(a[1]), .B(b[1]), .BUSY(busy[1]),
    .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(ec1), .FIRST_FAIL(ff[1])
  );
  xor4_gate_tester #(.SETTLE(1), .ERRW(9)) u2 (
    .CLK(clk), .RST(rst), .START(start), .Y(y[2]), .A(a[2]), .B(b[2]), .BUSY(busy[2]),
    .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(ec2), .FIRST_FAIL(ff[2])
  );
  xor4_gate_tester #(.SETTLE(3), .ERRW(9)) u3 (
    .CLK(clk), .RST(rst), .START(start), .Y(y[3]), .A(a[3]), .B(b[3]), .BUSY(busy[3]),
    .DONE(done[3]), .PASS(pass[3]), .ERR_CNT(ec3), .FIRST_FAIL(ff[3])
  );

  // Register-delayed gate: u2 sees 1 cycle of delay, u3 sees 3 cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      pipe[k][0] <= a[k] ^ b[k];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      y[k] = a[k] ^ b[k];
      case (mode[k])
        1:       y[k] = (a[k] ^ b[k]) & 4'hE;
        2:       y[k] = ~(a[k] ^ b[k]);
        3:       y[k] = (k == 3) ? pipe[k][2] : pipe[k][0];
        4:       y[k] = a[k] ^ b[k] ^ mask[{a[k], b[k]}];
        default: y[k] = a[k] ^ b[k];
      endcase
    end
  end

  function automatic logic [31:0] get_ec(input int k);
    case (k)
      0:       return 32'(ec0);
      1:       return 32'(ec1);
      2:       return 32'(ec2);
      default: return 32'(ec3);
    endcase
  endfunction

  // Behavioural reference: what a settled gate with the given fault returns for every
  // vector, then counted. Delays shorter than SETTLE+1 are invisible, so mode 3 is ideal.
  function automatic void ref_run(input int md, input int errw, output int cnt,
                                  output int first);
    logic [3:0] av, bv, x, yv;
    cnt   = 0;
    first = 0;
    for (int v = 0; v < 256; v++) begin
      av = 4'(v >> 4);
      bv = 4'(v);
      x  = av ^ bv;
      case (md)
        1:       yv = {x[3:1], 1'b0};
        2:       yv = ~x;
        4:       yv = x ^ mask[v];
        default: yv = x;
      endcase
      if (yv != x) begin
        if (cnt == 0) first = v;
        cnt++;
      end
    end
    if (cnt > (1 << errw) - 1) cnt = (1 << errw) - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s u%0d busy", tag, k), 32'(busy[k]), 0);
      chk($sformatf("%s u%0d done", tag, k), 32'(done[k]), 0);
      chk($sformatf("%s u%0d pass", tag, k), 32'(pass[k]), 0);
      chk($sformatf("%s u%0d ab", tag, k), 32'({a[k], b[k]}), 0);
      chk($sformatf("%s u%0d errcnt", tag, k), get_ec(k), 0);
      chk($sformatf("%s u%0d firstfail", tag, k), 32'(ff[k]), 0);
    end
  endtask

  task automatic new_mask();
    for (int v = 0; v < 256; v++) begin
      mask[v] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    end
  endtask

  // One run of all instances. poke_at pulses START mid-run; rst_at aborts with RST.
  task automatic run(input string tag, input int poke_at, input int rst_at);
    int bcnt [4];
    int serr [4];
    int ecnt, efirst;
    bit fin;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bcnt[k] = 0;
      serr[k] = 0;
      chk($sformatf("%s u%0d start busy", tag, k), 32'(busy[k]), 1);
      chk($sformatf("%s u%0d start done", tag, k), 32'(done[k]), 0);
      chk($sformatf("%s u%0d start pass", tag, k), 32'(pass[k]), 0);
      chk($sformatf("%s u%0d start errcnt", tag, k), get_ec(k), 0);
      chk($sformatf("%s u%0d start ab", tag, k), 32'({a[k], b[k]}), 0);
    end
    fin = 1'b0;
    for (int s = 0; s < 1500; s++) begin
      fin = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (busy[k]) begin
          if ({a[k], b[k]} != 8'(bcnt[k] / (S[k] + 1))) serr[k]++;
          bcnt[k]++;
        end
        if (!done[k]) fin = 1'b0;
      end
      if (fin) break;
      if (s == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset($sformatf("%s abort", tag));
        return;
      end
      start = (s == poke_at);
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s completion", tag), 32'(fin), 1);
    for (int k = 0; k < 4; k++) begin
      ref_run(mode[k], EW[k], ecnt, efirst);
      chk($sformatf("%s u%0d busy cycles", tag, k), 32'(bcnt[k]), 32'(256 * (S[k] + 1)));
      chk($sformatf("%s u%0d sequence errors", tag, k), 32'(serr[k]), 0);
      chk($sformatf("%s u%0d done", tag, k), 32'(done[k]), 1);
      chk($sformatf("%s u%0d busy", tag, k), 32'(busy[k]), 0);
      chk($sformatf("%s u%0d pass", tag, k), 32'(pass[k]), 32'(ecnt == 0));
      chk($sformatf("%s u%0d errcnt", tag, k), get_ec(k), 32'(ecnt));
      chk($sformatf("%s u%0d firstfail", tag, k), 32'(ff[k]), 32'(efirst));
      chk($sformatf("%s u%0d final ab", tag, k), 32'({a[k], b[k]}), 32'h0000_00FF);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) mode[k] = 0;
    for (int v = 0; v < 256; v++) mask[v] = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    // Ideal / inverted-saturating / delayed gates.
    mode = '{0, 2, 3, 3};
    run("ideal", -1, -1);

    // Stuck bit, saturation again, random faults.
    new_mask();
    mode = '{1, 2, 4, 4};
    run("faults", -1, -1);

    // Recovery from failing runs; full 256-error count on u0.
    new_mask();
    mode = '{2, 0, 0, 4};
    run("recover", -1, -1);

    // Ignored mid-run START, then RST abort.
    new_mask();
    mode = '{4, 4, 4, 4};
    run("abort", 50, 100);

    // Fresh run after abort.
    new_mask();
    mode = '{4, 2, 3, 3};
    run("fresh", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
